// File: rtl/pipe_stage_pkg.sv
// Shared processor definitions: control-field layout, default width and the NOP control word.
package pipe_stage_pkg;

    localparam int CTRL_W_DEF = 8;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_ALUOP_LO = 2;
    localparam int CTRL_ALUOP_HI = 3;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_REGSTORE = 6;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: valid bit plus ctrl/data register.
// The ctrl output reads as NOP whenever the entry is invalid; data keeps its last value.
module pipe_entry
    import pipe_stage_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            ctrl_d  = ld_ctrl;
            data_d  = ld_data;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = valid_q ? ctrl_q : CTRL_W'(CTRL_NOP);
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with a skid entry: full throughput, one-cycle latency,
// and in_ready taken from a flop so out_ready never reaches it combinationally.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_v, skid_v;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              main_ld, main_clr, main_src_skid, skid_ld, skid_clr;
    logic              main_v_nxt, skid_v_nxt;
    logic [CTRL_W-1:0] main_ld_ctrl;
    logic [DATA_W-1:0] main_ld_data;
    logic              in_ready_q, in_ready_d;
    logic [1:0]        occ_q, occ_d;
    logic              in_xfer, out_xfer, main_free;

    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = main_v && out_ready;
    assign main_free = out_xfer || !main_v;

    always_comb begin
        main_ld       = 1'b0;
        main_clr      = 1'b0;
        main_src_skid = 1'b0;
        skid_ld       = 1'b0;
        skid_clr      = 1'b0;
        main_v_nxt    = main_v;
        skid_v_nxt    = skid_v;
        if (flush) begin
            main_clr   = 1'b1;
            skid_clr   = 1'b1;
            main_v_nxt = 1'b0;
            skid_v_nxt = 1'b0;
        end else if (main_free) begin
            // Skid refills main first; input is never accepted while skid is full.
            skid_v_nxt = 1'b0;
            if (skid_v) begin
                main_ld       = 1'b1;
                main_src_skid = 1'b1;
                skid_clr      = 1'b1;
                main_v_nxt    = 1'b1;
            end else if (in_xfer) begin
                main_ld    = 1'b1;
                main_v_nxt = 1'b1;
            end else begin
                main_clr   = 1'b1;
                main_v_nxt = 1'b0;
            end
        end else if (in_xfer) begin
            skid_ld    = 1'b1;
            skid_v_nxt = 1'b1;
        end
        main_ld_ctrl = main_src_skid ? skid_ctrl : in_ctrl;
        main_ld_data = main_src_skid ? skid_data : in_data;
        in_ready_d   = !skid_v_nxt;
        occ_d        = {1'b0, main_v_nxt} + {1'b0, skid_v_nxt};
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else begin
            in_ready_q <= in_ready_d;
            occ_q      <= occ_d;
        end
    end

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk     (CLK),
        .rst_n   (Reset),
        .load    (main_ld),
        .clear   (main_clr),
        .ld_ctrl (main_ld_ctrl),
        .ld_data (main_ld_data),
        .valid   (main_v),
        .ctrl    (out_ctrl),
        .data    (out_data)
    );

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (CLK),
        .rst_n   (Reset),
        .load    (skid_ld),
        .clear   (skid_clr),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (skid_v),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
    );

    assign out_valid = main_v;
    assign in_ready  = in_ready_q;
    assign occupancy = occ_q;

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the datapath payload width (operands, immediate, PC+2, register indices packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 8, SHALL set the control-field width (RegWrite, ALUSrc, ALUOP, MemWrite, MemRead, RegStore packed).
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge only.
REQ-004 Reset  input  1  SHALL be a synchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL indicate that upstream presents a valid instruction.
REQ-006 in_ready  output  1  SHALL indicate that the stage accepts input this cycle.
REQ-007 in_ctrl  input  CTRL_W  SHALL carry the upstream control field.
REQ-008 in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-009 flush  input  1  SHALL discard all held instructions.
REQ-010 out_valid  output  1  SHALL indicate a valid instruction on the outputs.
REQ-011 out_ready  input  1  SHALL indicate that downstream accepts output this cycle.
REQ-012 out_ctrl  output  CTRL_W  SHALL carry the held control field.
REQ-013 out_data  output  DATA_W  SHALL carry the held payload.
REQ-014 occupancy  output  2  SHALL report the number of held entries (0..2).

Function
REQ-015 The stage SHALL hold a main entry (drives outputs) and a skid entry, each with a valid bit.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL equal NOT skid_valid, registered, with no combinational path from out_ready.
REQ-018 Latency SHALL be one cycle: an input accepted at edge N into an empty stage SHALL appear on the outputs after edge N.
REQ-019 With main full, out_ready=0 and an input transfer, the input SHALL be captured in the skid entry.
REQ-020 On an output transfer with skid full, the skid entry SHALL move to main and skid SHALL become empty in the same edge.
REQ-021 On an output transfer with skid empty and a simultaneous input transfer, the input SHALL replace main with no bubble, sustaining one transfer per cycle.
REQ-022 Order SHALL be preserved; no entry SHALL be duplicated or dropped, except under flush or reset.
REQ-023 out_ctrl SHALL be all-zero whenever out_valid=0, so that a bubble is a NOP; out_data SHALL hold its last value while out_valid=0.
REQ-024 flush=1 SHALL clear both valid bits at the next edge; an input transferred in the flush cycle SHALL be discarded; flush SHALL take priority over all transfers.
REQ-025 occupancy SHALL equal main_valid + skid_valid, registered.

Reset
REQ-026 When Reset=0 at a rising edge, main_valid and skid_valid SHALL become 0, and out_ctrl, out_data and occupancy SHALL become 0.
REQ-027 While Reset=0, in_ready SHALL become 1 after the first edge.
REQ-028 Reset SHALL take priority over flush and transfers, including mid-stall with the skid entry full.

Structure
REQ-029 The shared processor package SHALL hold the control-field bit positions, the CTRL_W default and the NOP (all-zero) control constant.
REQ-030 A single sub-module, pipe_entry (valid bit plus ctrl/data register with load, clear and zero-ctrl-on-invalid behaviour), SHALL be instantiated twice.

Verification
REQ-031 Reset=0 for 2 cycles, then in_valid=1 with ctrl=8'h21, data=64'h1234 -> after 1 edge: out_valid=1, out_ctrl=8'h21, out_data=64'h1234, occupancy=1.
REQ-032 Streaming: 8 back-to-back inputs with out_ready=1 -> 8 outputs in order on consecutive cycles, in_ready constantly 1.
REQ-033 Stall: out_ready=0 with inputs A,B,C -> A on the outputs, B in skid, in_ready=0, occupancy=2, C held upstream; out_ready=1 -> A, B, C delivered in order.
REQ-034 Flush with occupancy=2 and in_valid=1 -> next cycle: out_valid=0, out_ctrl=8'h00, occupancy=0, input discarded.
REQ-035 Reset=0 asserted mid-stall with skid full -> all outputs 0 after the edge; the first post-reset input passes with 1-cycle latency.
REQ-036 Randomised in_valid/out_ready over 1000 cycles against a scoreboard -> no loss, no duplication, order preserved.
